avalon_st_seq_source: RTL and testbench

//  Parametrised Avalon-ST source: emits packets of BEAT_COUNT beats, data START_VAL, +STEP, ...

---
 rtl/avalon_st_seq_source.sv | 135 +++++++++++++
 tb/tb_avalon_st_seq_source.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_st_seq_source.sv
// Avalon-ST sequence source: fixed-length packets START_VAL, +STEP, ... with SOP/EOP, loop, gap, packet count.
// All outputs registered; beat 0 visible the cycle after launch; beats hold while ready=0. Option: AVST_SRC_CHANNEL_EN.
module avalon_st_seq_source #(
   parameter int DATA_W     = 8,
   parameter int START_VAL  = 4,
   parameter int STEP       = 1,
   parameter int BEAT_COUNT = 3,
   parameter int GAP_CYCLES = 0
`ifdef AVST_SRC_CHANNEL_EN
   , parameter int CHAN_W   = 2
`endif
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              loop,
   input  logic              ready,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              sop,
   output logic              eop,
   output logic              busy,
   output logic [15:0]       pkt_count
`ifdef AVST_SRC_CHANNEL_EN
   , output logic [CHAN_W-1:0] channel
`endif
);

   localparam int BW = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [BW-1:0]     LAST_BEAT     = BW'(BEAT_COUNT - 1);
   localparam logic [BW-1:0]     BEAT_ONE      = BW'(1);
   localparam logic [GW-1:0]     LAST_GAP      = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [GW-1:0]     GAP_ONE       = GW'(1);
   localparam logic [DATA_W-1:0] FIRST         = DATA_W'(START_VAL);
   localparam logic [DATA_W-1:0] INC           = DATA_W'(STEP);
   localparam logic              FIRST_IS_LAST = (BEAT_COUNT == 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t          state;
   logic [BW-1:0]   beat_idx;
   logic [GW-1:0]   gap_cnt;
   logic            go;

   assign go = start | loop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         valid     <= 1'b0;
         data      <= '0;
         sop       <= 1'b0;
         eop       <= 1'b0;
         busy      <= 1'b0;
         pkt_count <= '0;
         beat_idx  <= '0;
         gap_cnt   <= '0;
`ifdef AVST_SRC_CHANNEL_EN
         channel   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state    <= SEND;
                  valid    <= 1'b1;
                  busy     <= 1'b1;
                  data     <= FIRST;
                  sop      <= 1'b1;
                  eop      <= FIRST_IS_LAST;
                  beat_idx <= '0;
               end
            end
            SEND: begin
               // valid is always high in SEND, so ready alone marks a transfer
               if (ready) begin
                  if (eop) begin
                     pkt_count <= pkt_count + 16'd1;
`ifdef AVST_SRC_CHANNEL_EN
                     channel   <= channel + CHAN_W'(1);
`endif
                     if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        valid   <= 1'b0;
                        sop     <= 1'b0;
                        eop     <= 1'b0;
                        gap_cnt <= '0;
                     end else if (go) begin
                        data     <= FIRST;
                        sop      <= 1'b1;
                        eop      <= FIRST_IS_LAST;
                        beat_idx <= '0;
                     end else begin
                        state <= IDLE;
                        valid <= 1'b0;
                        sop   <= 1'b0;
                        eop   <= 1'b0;
                        busy  <= 1'b0;
                     end
                  end else begin
                     data     <= data + INC;
                     beat_idx <= beat_idx + BEAT_ONE;
                     sop      <= 1'b0;
                     eop      <= (beat_idx + BEAT_ONE == LAST_BEAT);
                  end
               end
            end
            GAP: begin
               if (gap_cnt == LAST_GAP) begin
                  if (go) begin
                     state    <= SEND;
                     valid    <= 1'b1;
                     data     <= FIRST;
                     sop      <= 1'b1;
                     eop      <= FIRST_IS_LAST;
                     beat_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end
            end
            default: begin
               state <= IDLE;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Scoreboard bench: three source configurations share start/loop/ready; a packet-level model predicts beats and timing.
module tb_avalon_st_seq_source;

   logic clk    = 1'b0;
   logic resetn = 1'b1;
   logic start  = 1'b0;
   logic loop   = 1'b0;
   logic ready  = 1'b0;
   bit   done   = 1'b0;
   int   n_cmp  = 0;
   int   n_err  = 0;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
      logic [1:0] ch;
   } beat_t;

   task automatic chk(input string nm, input int g, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 60)
            $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d", nm, g, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : u
      localparam int ST = (g == 0) ? 4 : (g == 1) ? 254 : 250;
      localparam int SP = (g == 2) ? 7 : 1;
      localparam int BC = (g == 0) ? 3 : (g == 1) ? 4 : 1;
      localparam int GC = (g == 1) ? 2 : 0;

      logic       valid, sop, eop, busy;
      logic [7:0] data;
      logic [15:0] pkt_count;
`ifdef AVST_SRC_CHANNEL_EN
      logic [1:0] channel;
`endif

      avalon_st_seq_source #(
         .DATA_W(8), .START_VAL(ST), .STEP(SP), .BEAT_COUNT(BC), .GAP_CYCLES(GC)
`ifdef AVST_SRC_CHANNEL_EN
         , .CHAN_W(2)
`endif
      ) dut (
         .clk(clk), .resetn(resetn), .start(start), .loop(loop), .ready(ready),
         .valid(valid), .data(data), .sop(sop), .eop(eop), .busy(busy),
         .pkt_count(pkt_count)
`ifdef AVST_SRC_CHANNEL_EN
         , .channel(channel)
`endif
      );

      // model: mode 0 idle, 1 sending, 2 gap; expected beats queued whole-packet at launch
      beat_t q[$];
      int mode = 0, bidx = 0, gleft = 0, pkts = 0;

      always @(posedge clk) begin : mdl
         bit go, launch;
         beat_t b;
         if (!resetn) begin
            mode = 0; bidx = 0; gleft = 0; pkts = 0;
            q.delete();
         end else begin
            go = start | loop;
            launch = 1'b0;
            case (mode)
               0: launch = go;
               1: if (ready) begin
                     if (bidx == BC - 1) begin
                        pkts = (pkts + 1) % 65536;
                        if (GC > 0) begin mode = 2; gleft = GC; end
                        else if (go) launch = 1'b1;
                        else mode = 0;
                     end else bidx++;
                  end
               default: begin
                  gleft--;
                  if (gleft == 0) begin
                     if (go) launch = 1'b1;
                     else mode = 0;
                  end
               end
            endcase
            if (launch) begin
               mode = 1; bidx = 0;
               for (int i = 0; i < BC; i++) begin
                  b.d  = 8'((ST + i * SP) % 256);
                  b.s  = (i == 0);
                  b.e  = (i == BC - 1);
                  b.ch = 2'(pkts % 4);
                  q.push_back(b);
               end
            end
         end
      end

      always @(negedge clk) begin
         if (resetn) begin
            chk("valid", g, int'(valid), int'(mode == 1));
            chk("busy", g, int'(busy), int'(mode != 0));
            chk("pkt_count", g, int'(pkt_count), pkts);
            if (valid) begin
               if (q.size() == 0) chk("beat_expected", g, 0, 1);
               else begin
                  chk("data", g, int'(data), int'(q[0].d));
                  chk("sop", g, int'(sop), int'(q[0].s));
                  chk("eop", g, int'(eop), int'(q[0].e));
`ifdef AVST_SRC_CHANNEL_EN
                  chk("channel", g, int'(channel), int'(q[0].ch));
`endif
                  if (ready) void'(q.pop_front());
               end
            end
         end
      end

      always @(negedge resetn) begin
         #1;
         chk("rst_valid", g, int'(valid), 0);
         chk("rst_data", g, int'(data), 0);
         chk("rst_sop", g, int'(sop), 0);
         chk("rst_eop", g, int'(eop), 0);
         chk("rst_busy", g, int'(busy), 0);
         chk("rst_pkt_count", g, int'(pkt_count), 0);
`ifdef AVST_SRC_CHANNEL_EN
         chk("rst_channel", g, int'(channel), 0);
`endif
      end

      always @(posedge done) begin
         chk("drain_queue", g, q.size(), 0);
         chk("drain_busy", g, int'(busy), 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   initial begin
      logic [5:0] pat;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #3 resetn = 1'b1;
      cyc(1);

      // single shot, sink always ready
      ready = 1'b1;
      pulse_start();
      cyc(15);

      // stalling sink: ready 1,0,0,1,0,1 repeating
      pat = 6'b101001;
      start = 1'b1;
      ready = pat[0];
      cyc(1);
      start = 1'b0;
      for (int k = 1; k < 36; k++) begin
         ready = pat[k % 6];
         cyc(1);
      end
      ready = 1'b1;
      cyc(10);

      // looped traffic, then loop dropped mid-packet
      loop = 1'b1;
      cyc(47);
      loop = 1'b0;
      cyc(20);

      // async reset during beat 1, then restart
      pulse_start();
      @(posedge clk);
      #3 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #3 resetn = 1'b1;
      cyc(2);
      pulse_start();
      cyc(15);

      // random start/loop/ready
      for (int k = 0; k < 2000; k++) begin
         start = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 39) == 0) loop = ~loop;
         ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end

      start = 1'b0;
      loop  = 1'b0;
      ready = 1'b1;
      cyc(30);
      done = 1'b1;
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
